// File: rtl/riscv_ctrl_pkg.sv
// Shared types and default widths for the RISC-V run controller / IMEM loader.
package riscv_ctrl_pkg;

    localparam int DATA_WIDTH_DEF      = 32;
    localparam int CNT_WIDTH_DEF       = 32;
    localparam int IMEM_ADDR_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/riscv_core_ctrl_rise_pulse.sv
// Rising-edge detector: previous level is registered, pulse is high on the edge cycle.
module rise_pulse (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) level_q <= 1'b0;
        else                level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/riscv_core_ctrl.sv
// Run controller and IMEM loader behind the AXI4-Lite register slave.
// Optional macro RISCV_HALT_DETECT_EN adds i_core_halt to end a run early.
module riscv_core_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    input  logic                       i_run,
    input  logic [CNT_WIDTH-1:0]       i_num_cycle,
    input  logic                       i_mem_reset_n,
    input  logic                       i_instruction_write,
    input  logic [31:0]                i_imem_addr,
    input  logic [DATA_WIDTH-1:0]      i_imem_wdata,
`ifdef RISCV_HALT_DETECT_EN
    input  logic                       i_core_halt,
`endif
    output logic                       o_idle,
    output logic                       o_running,
    output logic                       o_done,
    output logic                       o_core_en,
    output logic                       o_core_rst_n,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0]      o_imem_wdata,
    output logic [CNT_WIDTH-1:0]       o_cycle_cnt
);

    ctrl_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, n_q;
    logic                 start, halt, wr_edge;
    logic                 unused_addr_bits;

`ifdef RISCV_HALT_DETECT_EN
    assign halt = i_core_halt;
`else
    assign halt = 1'b0;
`endif

    // Byte-lane bits and bits above the IMEM depth are deliberately dropped.
    assign unused_addr_bits = &{1'b0, i_imem_addr[31:IMEM_ADDR_WIDTH+2], i_imem_addr[1:0]};

    rise_pulse u_wr_edge (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .level        (i_instruction_write),
        .pulse        (wr_edge)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_run && i_mem_reset_n) begin
                    start   = 1'b1;
                    state_d = (i_num_cycle == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Memory reset aborts silently and wins over expiry/halt.
                if (!i_mem_reset_n)
                    state_d = ST_IDLE;
                else if (cnt_q == n_q - CNT_WIDTH'(1) || halt)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            o_core_rst_n <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
        end else begin
            state_q      <= state_d;
            o_core_rst_n <= i_mem_reset_n;
            if (start) begin
                cnt_q <= '0;
                n_q   <= i_num_cycle;
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            o_imem_we <= wr_edge && (state_q == ST_IDLE);
            if (wr_edge && (state_q == ST_IDLE)) begin
                o_imem_addr  <= i_imem_addr[IMEM_ADDR_WIDTH+1:2];
                o_imem_wdata <= i_imem_wdata;
            end
        end
    end

    assign o_idle      = (state_q == ST_IDLE);
    assign o_running   = (state_q == ST_RUN);
    assign o_done      = (state_q == ST_DONE);
    assign o_core_en   = o_running;
    assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_core_ctrl.sv
// Directed bench for riscv_core_ctrl; halt scenario built when RISCV_HALT_DETECT_EN is defined.
module tb_riscv_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_run;
    logic [31:0] i_num_cycle;
    logic        i_mem_reset_n;
    logic        i_instruction_write;
    logic [31:0] i_imem_addr;
    logic [31:0] i_imem_wdata;
    logic        i_core_halt;
    logic        o_idle, o_running, o_done, o_core_en, o_core_rst_n, o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata, o_cycle_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_core_ctrl dut (
        .S_AXI_ACLK         (clk),
        .S_AXI_ARESETN      (rst_n),
        .i_run              (i_run),
        .i_num_cycle        (i_num_cycle),
        .i_mem_reset_n      (i_mem_reset_n),
        .i_instruction_write(i_instruction_write),
        .i_imem_addr        (i_imem_addr),
        .i_imem_wdata       (i_imem_wdata),
`ifdef RISCV_HALT_DETECT_EN
        .i_core_halt        (i_core_halt),
`endif
        .o_idle             (o_idle),
        .o_running          (o_running),
        .o_done             (o_done),
        .o_core_en          (o_core_en),
        .o_core_rst_n       (o_core_rst_n),
        .o_imem_we          (o_imem_we),
        .o_imem_addr        (o_imem_addr),
        .o_imem_wdata       (o_imem_wdata),
        .o_cycle_cnt        (o_cycle_cnt)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_run = 0; i_num_cycle = 0; i_mem_reset_n = 0;
        i_instruction_write = 0; i_imem_addr = 0; i_imem_wdata = 0; i_core_halt = 0;
        #23;
        checks++;
        if ({o_idle, o_running, o_done, o_core_en, o_core_rst_n, o_imem_we} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags got=%b exp=100000",
                {o_idle, o_running, o_done, o_core_en, o_core_rst_n, o_imem_we});
        end
        checks++;
        if (o_imem_addr !== 8'h0 || o_imem_wdata !== 32'h0 || o_cycle_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_regs addr=%h wdata=%h cnt=%0d exp all 0",
                o_imem_addr, o_imem_wdata, o_cycle_cnt);
        end
        rst_n = 1'b1;
        step(); step();
        i_mem_reset_n = 1'b1;
        checks++;
        if (o_core_rst_n !== 1'b0) begin
            errors++; $display("FAIL core_rst_lag got=%b exp=0", o_core_rst_n);
        end
        step();
        checks++;
        if (o_core_rst_n !== 1'b1 || o_idle !== 1'b1 || o_core_en !== 1'b0) begin
            errors++; $display("FAIL core_rst_follow rst=%b idle=%b en=%b exp 1 1 0",
                o_core_rst_n, o_idle, o_core_en);
        end
    endtask

    task automatic test_run5();
        i_num_cycle = 5; i_run = 1;
        step();                                   // now cycle t+1
        i_run = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin i_num_cycle = 2; i_run = 1; end   // ignored: running, N latched
            if (k == 3) i_run = 0;
            checks++;
            if (o_core_en !== 1'b1 || o_running !== 1'b1 || o_done !== 1'b0) begin
                errors++; $display("FAIL run5_en k=%0d en=%b run=%b done=%b exp 1 1 0",
                    k, o_core_en, o_running, o_done);
            end
            step();
        end
        checks++;
        if (o_done !== 1'b1 || o_core_en !== 1'b0 || o_cycle_cnt !== 32'd5) begin
            errors++; $display("FAIL run5_done done=%b en=%b cnt=%0d exp 1 0 5",
                o_done, o_core_en, o_cycle_cnt);
        end
        step();
        checks++;
        if (o_idle !== 1'b1 || o_done !== 1'b0 || o_cycle_cnt !== 32'd5) begin
            errors++; $display("FAIL run5_idle idle=%b done=%b cnt=%0d exp 1 0 5",
                o_idle, o_done, o_cycle_cnt);
        end
        step();
        checks++;
        if (o_idle !== 1'b1) begin
            errors++; $display("FAIL run5_noqueue idle=%b exp 1", o_idle);
        end
    endtask

    task automatic test_zero_len();
        i_num_cycle = 0; i_run = 1;
        step();
        i_run = 0;
        checks++;
        if (o_done !== 1'b1 || o_core_en !== 1'b0 || o_cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL zero_done done=%b en=%b cnt=%0d exp 1 0 0",
                o_done, o_core_en, o_cycle_cnt);
        end
        step();
        checks++;
        if (o_idle !== 1'b1 || o_core_en !== 1'b0) begin
            errors++; $display("FAIL zero_idle idle=%b en=%b exp 1 0", o_idle, o_core_en);
        end
    endtask

    task automatic test_imem_load();
        int pulses;
        i_imem_addr = 32'h0000_0404; i_imem_wdata = 32'hDEAD_BEEF; i_instruction_write = 1;
        step();
        checks++;
        if (o_imem_we !== 1'b1 || o_imem_addr !== 8'h01 || o_imem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_first we=%b addr=%h data=%h exp 1 01 deadbeef",
                o_imem_we, o_imem_addr, o_imem_wdata);
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_imem_we) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL load_level extra_pulses=%0d exp 0", pulses);
        end
        i_instruction_write = 0;
        step();
        i_imem_addr = 32'hFFFF_F3FF; i_imem_wdata = 32'h1234_5678; i_instruction_write = 1;
        step();
        i_instruction_write = 0;
        checks++;
        if (o_imem_we !== 1'b1 || o_imem_addr !== 8'hFF || o_imem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL load_wrap we=%b addr=%h data=%h exp 1 ff 12345678",
                o_imem_we, o_imem_addr, o_imem_wdata);
        end
        step();
        checks++;
        if (o_imem_we !== 1'b0) begin
            errors++; $display("FAIL load_single we=%b exp 0", o_imem_we);
        end
    endtask

    task automatic test_abort();
        int guard;
        i_num_cycle = 100; i_run = 1;
        step();
        i_run = 0;
        step(); step();
        i_imem_addr = 32'h0000_0010; i_imem_wdata = 32'hCAFE_F00D; i_instruction_write = 1;
        step();
        i_instruction_write = 0;
        checks++;
        if (o_imem_we !== 1'b0 || o_imem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL run_load_drop we=%b data=%h exp 0 12345678",
                o_imem_we, o_imem_wdata);
        end
        guard = 0;
        while (o_cycle_cnt !== 32'd40 && guard < 200) begin step(); guard++; end
        checks++;
        if (o_cycle_cnt !== 32'd40 || o_running !== 1'b1) begin
            errors++; $display("FAIL abort_reach cnt=%0d run=%b exp 40 1", o_cycle_cnt, o_running);
        end
        i_mem_reset_n = 0;
        step();
        checks++;
        if (o_idle !== 1'b1 || o_done !== 1'b0 || o_cycle_cnt !== 32'd41 || o_core_rst_n !== 1'b0) begin
            errors++; $display("FAIL abort_idle idle=%b done=%b cnt=%0d rst=%b exp 1 0 41 0",
                o_idle, o_done, o_cycle_cnt, o_core_rst_n);
        end
        i_num_cycle = 3; i_run = 1;               // ignored while memory reset is low
        step();
        i_run = 0;
        checks++;
        if (o_idle !== 1'b1 || o_done !== 1'b0 || o_cycle_cnt !== 32'd41) begin
            errors++; $display("FAIL abort_hold idle=%b done=%b cnt=%0d exp 1 0 41",
                o_idle, o_done, o_cycle_cnt);
        end
        i_mem_reset_n = 1;
        step(); step();
    endtask

`ifdef RISCV_HALT_DETECT_EN
    task automatic test_halt();
        i_core_halt = 1;
        step();
        i_core_halt = 0;
        checks++;
        if (o_idle !== 1'b1) begin
            errors++; $display("FAIL halt_idle_ignored idle=%b exp 1", o_idle);
        end
        i_num_cycle = 50; i_run = 1;
        step();                                   // enabled cycle 1
        i_run = 0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) i_run = 1;
            if (k == 6) i_run = 0;
            step();
        end
        checks++;
        if (o_core_en !== 1'b1 || o_cycle_cnt !== 32'd9) begin
            errors++; $display("FAIL halt_pre en=%b cnt=%0d exp 1 9", o_core_en, o_cycle_cnt);
        end
        i_core_halt = 1;
        step();
        i_core_halt = 0;
        checks++;
        if (o_done !== 1'b1 || o_core_en !== 1'b0 || o_cycle_cnt !== 32'd10) begin
            errors++; $display("FAIL halt_done done=%b en=%b cnt=%0d exp 1 0 10",
                o_done, o_core_en, o_cycle_cnt);
        end
        step();
        checks++;
        if (o_idle !== 1'b1) begin
            errors++; $display("FAIL halt_back_idle idle=%b exp 1", o_idle);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run5();
        test_zero_len();
        test_imem_load();
        test_abort();
`ifdef RISCV_HALT_DETECT_EN
        test_halt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
